fetch_unit: RTL and testbench

Instruction-fetch stage that produces the `pc_plus_four` / `out_instruction` pair consumed by the IF/ID pipeline register. It owns the program counter and issues one-outstanding-request reads to instruction memory over a req/gnt/rvalid handshake. It holds a fetched instruction until the IF/ID register accepts it (`hold` low), and squashes stale fetches on branch/jump redirect. When no instruction is ready, it drives a NOP bubble.

---
 rtl/fetch_unit.sv | 103 ++++++++++
 tb/tb_fetch_unit.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues single-outstanding imem reads,
// and presents one fetched instruction (or a NOP bubble) to the IF/ID register.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP      = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        hold,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc_plus_four,
    output logic [31:0] out_instruction,
    output logic        inst_valid
);

    localparam int unsigned XLEN = 32;

    typedef enum logic [1:0] {
        REQ  = 2'd0,
        WAIT = 2'd1,
        HAVE = 2'd2,
        DROP = 2'd3
    } state_t;

    state_t            state, state_nx;
    logic [XLEN-1:0]   pc, pc_nx;
    logic [XLEN-1:0]   inst_nx, ppf_nx;
    logic              valid_nx;

    // State and output registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state           <= REQ;
            pc              <= RESET_PC;
            out_instruction <= NOP;
            pc_plus_four    <= '0;
            inst_valid      <= 1'b0;
        end else begin
            state           <= state_nx;
            pc              <= pc_nx;
            out_instruction <= inst_nx;
            pc_plus_four    <= ppf_nx;
            inst_valid      <= valid_nx;
        end
    end

    // Next-state logic; a redirect flushes regardless of hold, and any read
    // still in flight is routed through DROP so its data is discarded.
    always_comb begin
        state_nx = state;
        pc_nx    = pc;
        inst_nx  = out_instruction;
        ppf_nx   = pc_plus_four;
        valid_nx = inst_valid;

        if (redirect) begin
            pc_nx    = {redirect_pc[XLEN-1:2], 2'b00};
            inst_nx  = NOP;
            valid_nx = 1'b0;
            case (state)
                REQ:  state_nx = imem_gnt    ? DROP : REQ;
                WAIT: state_nx = imem_rvalid ? REQ  : DROP;
                HAVE: state_nx = REQ;
                DROP: state_nx = imem_rvalid ? REQ  : DROP;
            endcase
        end else begin
            case (state)
                REQ: begin
                    if (imem_gnt) state_nx = WAIT;
                end
                WAIT: begin
                    if (imem_rvalid) begin
                        inst_nx  = imem_rdata;
                        ppf_nx   = pc + XLEN'(4);
                        valid_nx = 1'b1;
                        pc_nx    = pc + XLEN'(4);
                        state_nx = HAVE;
                    end
                end
                HAVE: begin
                    if (!hold) begin
                        inst_nx  = NOP;
                        valid_nx = 1'b0;
                        state_nx = REQ;
                    end
                end
                DROP: begin
                    if (imem_rvalid) state_nx = REQ;
                end
            endcase
        end
    end

    assign imem_req  = (state == REQ);
    assign imem_addr = pc;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: transaction-level model checked every cycle, plus
// directed scenarios with literal expectations and a randomized phase.
`timescale 1ns/1ps
module tb_fetch_unit;

    localparam logic [31:0] NOPW = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset_n, hold, redirect;
    logic [31:0] redirect_pc;
    logic        imem_req, imem_gnt, imem_rvalid, inst_valid;
    logic [31:0] imem_addr, imem_rdata, pc_plus_four, out_instruction;

    logic        rst2_n, gnt2, rvalid2, hold2, redir2;
    logic [31:0] rdata2, rpc2;
    logic        req2, valid2;
    logic [31:0] addr2, ppf2, inst2;

    always #5 clk = ~clk;

    fetch_unit u_dut (
        .clk(clk), .reset_n(reset_n), .hold(hold), .redirect(redirect),
        .redirect_pc(redirect_pc), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .pc_plus_four(pc_plus_four), .out_instruction(out_instruction),
        .inst_valid(inst_valid)
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFFC), .NOP(32'h0000_0000)) u_dut2 (
        .clk(clk), .reset_n(rst2_n), .hold(hold2), .redirect(redir2),
        .redirect_pc(rpc2), .imem_req(req2), .imem_addr(addr2),
        .imem_gnt(gnt2), .imem_rvalid(rvalid2), .imem_rdata(rdata2),
        .pc_plus_four(ppf2), .out_instruction(inst2), .inst_valid(valid2)
    );

    int n_pass = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Reference model: PC, whether a read is in flight, whether it is stale,
    // and whether an instruction is being presented.
    logic        m_ok = 1'b0;
    logic [31:0] m_pc, m_inst, m_ppf;
    logic        m_pend, m_stale, m_have;

    always @(posedge clk) begin
        if (!reset_n) begin
            m_pc = 32'h0; m_pend = 0; m_stale = 0; m_have = 0;
            m_inst = NOPW; m_ppf = 32'h0; m_ok = 1'b1;
        end else if (m_ok) begin
            logic take, ret;
            take = !m_pend && !m_have && imem_gnt;
            ret  = m_pend && imem_rvalid;
            if (redirect) begin
                m_pc = {redirect_pc[31:2], 2'b00};
                m_have = 0; m_inst = NOPW;
                if (take) begin m_pend = 1; m_stale = 1; end
                else if (ret) begin m_pend = 0; m_stale = 0; end
                else if (m_pend) m_stale = 1;
            end else if (take) begin
                m_pend = 1; m_stale = 0;
            end else if (ret) begin
                if (!m_stale) begin
                    m_inst = imem_rdata; m_ppf = m_pc + 32'd4;
                    m_pc = m_pc + 32'd4; m_have = 1;
                end
                m_pend = 0; m_stale = 0;
            end else if (m_have && !hold) begin
                m_have = 0; m_inst = NOPW;
            end
        end
    end

    always @(negedge clk) begin
        if (m_ok) begin
            chk("imem_req", 32'(imem_req), 32'(!m_pend && !m_have));
            chk("imem_addr", imem_addr, m_pc);
            chk("inst_valid", 32'(inst_valid), 32'(m_have));
            chk("out_instruction", out_instruction, m_inst);
            chk("pc_plus_four", pc_plus_four, m_ppf);
        end
    end

    // Memory responder, run once per cycle just after the clock edge.
    logic        auto_mem = 0, force_en = 0, mem_busy = 0;
    logic [31:0] force_data, mem_data;
    int          gnt_pct = 100, lat_max = 1, mem_cnt = 0;

    task automatic step();
        @(posedge clk);
        #1;
        if (auto_mem) begin
            imem_gnt = 0; imem_rvalid = 0; imem_rdata = $urandom;
            if (mem_busy) begin
                if (mem_cnt == 0) begin
                    imem_rvalid = 1; imem_rdata = mem_data; mem_busy = 0;
                end else mem_cnt--;
            end else if (imem_req && reset_n && ($urandom_range(99) < 32'(gnt_pct))) begin
                imem_gnt = 1; mem_busy = 1;
                mem_cnt  = $urandom_range(lat_max, 1) - 1;
                mem_data = force_en ? force_data : (imem_addr ^ 32'hA5A5_0000);
            end
        end
    endtask

    task automatic do_reset();
        reset_n = 0; hold = 0; redirect = 0; redirect_pc = 0;
        auto_mem = 0; mem_busy = 0; force_en = 0;
        imem_gnt = 0; imem_rvalid = 0; imem_rdata = 0;
        step(); step();
        reset_n = 1;
    endtask

    logic [63:0] log_q[$];

    initial begin
        hold2 = 0; redir2 = 0; rpc2 = 0; rst2_n = 0; gnt2 = 0; rvalid2 = 0; rdata2 = 0;
        do_reset();

        // Reset PC at the top of the address space wraps to 0.
        step(); rst2_n = 1;
        @(negedge clk);
        chk("wrap_reset_addr", addr2, 32'hFFFF_FFFC);
        chk("wrap_reset_req", 32'(req2), 32'd1);
        gnt2 = 1;
        step(); gnt2 = 0; rvalid2 = 1; rdata2 = 32'h0000_1234;
        step(); rvalid2 = 0;
        @(negedge clk);
        chk("wrap_valid", 32'(valid2), 32'd1);
        chk("wrap_ppf", ppf2, 32'h0000_0000);
        chk("wrap_inst", inst2, 32'h0000_1234);
        step();
        @(negedge clk);
        chk("wrap_next_addr", addr2, 32'h0000_0000);
        chk("wrap_next_req", 32'(req2), 32'd1);

        // Reset values, then back-to-back fetches from a 1-cycle memory.
        @(negedge clk);
        chk("rst_valid", 32'(inst_valid), 32'd0);
        chk("rst_inst", out_instruction, NOPW);
        chk("rst_ppf", pc_plus_four, 32'd0);
        chk("rst_addr", imem_addr, 32'd0);
        auto_mem = 1; gnt_pct = 100; lat_max = 1;
        for (int i = 0; i < 10; i++) begin
            step();
            @(negedge clk);
            if (inst_valid) log_q.push_back({pc_plus_four, out_instruction});
        end
        chk("seq_count", 32'(log_q.size()), 32'd3);
        if (log_q.size() == 3) begin
            chk("seq0", log_q[0][31:0] ^ log_q[0][63:32], 32'hA5A5_0004);
            chk("seq0_ppf", log_q[0][63:32], 32'd4);
            chk("seq1", log_q[1][31:0], 32'hA5A5_0004);
            chk("seq1_ppf", log_q[1][63:32], 32'd8);
            chk("seq2", log_q[2][31:0], 32'hA5A5_0008);
            chk("seq2_ppf", log_q[2][63:32], 32'd12);
        end

        // Hold an instruction for five cycles, then release.
        do_reset();
        hold = 1; auto_mem = 1; force_en = 1; force_data = 32'h8C22_0004;
        begin
            int t;
            t = 0;
            @(negedge clk);
            while (!inst_valid && t < 20) begin
                step(); @(negedge clk); t++;
            end
            chk("hold_wait_timeout", 32'(inst_valid), 32'd1);
        end
        for (int i = 0; i < 5; i++) begin
            step(); @(negedge clk);
            chk("hold_valid", 32'(inst_valid), 32'd1);
            chk("hold_inst", out_instruction, 32'h8C22_0004);
            chk("hold_ppf", pc_plus_four, 32'd4);
            chk("hold_req", 32'(imem_req), 32'd0);
        end
        hold = 0;
        step(); @(negedge clk);
        chk("release_req", 32'(imem_req), 32'd1);
        chk("release_addr", imem_addr, 32'd4);
        force_en = 0;

        // Redirect while WAIT; the late response must be dropped.
        do_reset();
        imem_gnt = 1;
        step(); imem_gnt = 0; redirect = 1; redirect_pc = 32'h0000_0103;
        step(); redirect = 0;
        step(); imem_rvalid = 1; imem_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        chk("drop_req_off", 32'(imem_req), 32'd0);
        step(); imem_rvalid = 0;
        @(negedge clk);
        chk("drop_valid", 32'(inst_valid), 32'd0);
        chk("drop_inst", out_instruction, NOPW);
        chk("drop_req", 32'(imem_req), 32'd1);
        chk("drop_addr", imem_addr, 32'h0000_0100);
        step(); @(negedge clk);
        chk("drop_valid2", 32'(inst_valid), 32'd0);

        // Redirect and hold together in HAVE: flush wins.
        do_reset();
        imem_gnt = 1;
        step(); imem_gnt = 0; imem_rvalid = 1; imem_rdata = 32'h1111_0000;
        step(); imem_rvalid = 0; hold = 1; redirect = 1; redirect_pc = 32'h0000_0200;
        step(); redirect = 0;
        @(negedge clk);
        chk("flush_valid", 32'(inst_valid), 32'd0);
        chk("flush_inst", out_instruction, NOPW);
        chk("flush_ppf", pc_plus_four, 32'd4);
        chk("flush_req", 32'(imem_req), 32'd1);
        chk("flush_addr", imem_addr, 32'h0000_0200);
        hold = 0;

        // Withheld grant, then reset while WAIT.
        do_reset();
        imem_gnt = 1;
        step(); imem_gnt = 0; imem_rvalid = 1; imem_rdata = 32'h2222_0000;
        step(); imem_rvalid = 0;
        step();
        for (int i = 0; i < 4; i++) begin
            step(); @(negedge clk);
            chk("nognt_req", 32'(imem_req), 32'd1);
            chk("nognt_addr", imem_addr, 32'd4);
        end
        imem_gnt = 1;
        step(); imem_gnt = 0; reset_n = 0;
        step(); reset_n = 1;
        @(negedge clk);
        chk("midrst_valid", 32'(inst_valid), 32'd0);
        chk("midrst_inst", out_instruction, NOPW);
        chk("midrst_ppf", pc_plus_four, 32'd0);
        chk("midrst_addr", imem_addr, 32'd0);

        // Randomized traffic against the model.
        do_reset();
        auto_mem = 1; lat_max = 3;
        for (int i = 0; i < 3000; i++) begin
            step();
            gnt_pct     = $urandom_range(100, 20);
            hold        = ($urandom_range(9) < 3);
            redirect    = ($urandom_range(15) == 0);
            redirect_pc = $urandom;
            reset_n     = !($urandom_range(299) == 0);
            if (!reset_n) begin
                imem_gnt = 0; imem_rvalid = 0; mem_busy = 0;
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
